glitch_frontend: RTL and testbench
==================================

// Module: glitch_frontend
// PURPOSE
// - Clock-glitch front end for a fault-injection rig.
// - Divides the system clock into a clean target clock.
// - Watches a target GPIO for an armed edge and produces a trigger pulse.
// - Drives the target clock pin: the clean clock normally, a burst of full-rate pulses when fired.
// - Sits between the top-level pins and the delay/controller logic.
// PARAMETERS
// DIV          3  clk cycles per clean_clk period (>=2); 48 MHz/3 = 16 MHz
// RISING_EDGE  1  1: fire on GPIO rising edge; 0: fire on falling edge
// TRIG_CYCLES  2  trigger pulse width in clk cycles (>=1)
// N_CYCLES     2  fast pulses inserted per glitch (>=1)
// PORTS
// clk          in   1  system clock; all logic on posedge
// rst          in   1  asynchronous, active-high reset
// target_gpio  in   1  asynchronous target status pin
// arm          in   1  level; enables one edge detection
// trigger      out  1  TRIG_CYCLES-wide pulse on armed edge
// clean_clk    out  1  glitch-free divided clock
// target_clk   out  1  clock to target, glitched on demand
// glitch_busy  out  1  high while fast pulses are being emitted
// BEHAVIOUR
// - Reset (async): all outputs 0. Counters 0. Synchronizers 0. Armed/fired flags cleared.
// - Divider: cnt counts 0..DIV-1 and wraps.
//   - clean_clk is registered: high while cnt < DIV/2 (floor), else low.
//   - Period exactly DIV clk cycles. DIV=3 gives 1 cycle high, 2 low.
//   - Never stops; not affected by the glitcher.
// - Edge detect: target_gpio passes a 2-flop synchronizer (s1, s2), then a prev register (s3).
//   - Edge = s2 & ~s3 (rising) or ~s2 & s3 (falling).
//   - Fire condition: edge AND arm AND ~fired.
//   - On fire, trigger is registered high for exactly TRIG_CYCLES clk cycles.
//   - Latency: GPIO level sampled at edge E0 gives trigger high after E2.
//   - On fire, fired is set. fired clears only when arm is low. One shot per arm period.
//   - Edges while trigger is high, or while arm is low, are ignored and not queued.
// - Glitcher:
//   - Idle: target_clk <= clean_clk, a registered copy delayed 1 clk.
//   - Fire source: rising edge of the fire source (internal trigger; see CONFIGURATION) while idle.
//   - On fire: next cycle glitch_busy=1 and target_clk = 1,0,1,0... toggling every clk.
//   - Emits N_CYCLES pulses, each 1 clk high and 1 clk low: 2*N_CYCLES clk cycles in total.
//   - Afterwards glitch_busy=0 and target_clk resumes following clean_clk the next cycle.
//   - The resume takes no phase alignment.
//   - Fire-source edges while busy are ignored.
//   - Fire and burst completion in the same cycle: ends the burst, and the edge is dropped.
// - Reset mid-burst or mid-trigger: aborts immediately, outputs 0.
// CONFIGURATION
// - Macro GLITCH_EXT_TRIG_EN.
//   - Defined: adds input ext_trig (1 bit, synchronous to clk). The glitcher fires on rising
//     edges of ext_trig only, e.g. from the trigger_delay block. trigger is still output.
//   - Undefined: no ext_trig port. The glitcher fires directly on rising edges of trigger.
// TESTING
// - Reset release, defaults: clean_clk is periodic, 3 clk cycles per period (1 high, 2 low)
//   over 10 periods. target_clk is the same waveform delayed 1 clk.
// - arm=1, target_gpio 0->1 -> trigger high for 2 clks starting 3 clks later.
//   A second edge 20 clks later gives no trigger.
// - arm=0 during edge -> no trigger.
//   Then arm 1->0->1 and a new edge -> trigger fires once.
// - Trigger fires -> glitch_busy high 4 clks; target_clk = 1,0,1,0; then clean_clk resumes.
// - Assert rst during a burst -> target_clk, glitch_busy and trigger all go 0 immediately.
//   After release the divider restarts from cnt=0.
// - GLITCH_EXT_TRIG_EN defined: ext_trig pulse -> 4-cycle burst.
//   A GPIO edge alone -> trigger but no burst.

Source files
------------

// File: rtl/glitch_frontend_if.sv
// Pin-side bundle for the clock-glitch front end.
// GLITCH_EXT_TRIG_EN adds ext_trig, an external fire source that is synchronous to clk.
interface glitch_frontend_if;
  logic target_gpio;
  logic arm;
  logic trigger;
  logic clean_clk;
  logic target_clk;
  logic glitch_busy;
`ifdef GLITCH_EXT_TRIG_EN
  logic ext_trig;

  modport master (
    output target_gpio, arm, ext_trig,
    input  trigger, clean_clk, target_clk, glitch_busy
  );
  modport slave (
    input  target_gpio, arm, ext_trig,
    output trigger, clean_clk, target_clk, glitch_busy
  );
`else
  modport master (
    output target_gpio, arm,
    input  trigger, clean_clk, target_clk, glitch_busy
  );
  modport slave (
    input  target_gpio, arm,
    output trigger, clean_clk, target_clk, glitch_busy
  );
`endif
endinterface

// File: rtl/glitch_frontend.sv
// Clock-glitch front end: clean clock divider, armed GPIO edge trigger, fast-pulse burst glitcher.
// With GLITCH_EXT_TRIG_EN defined, the glitcher fires on ext_trig instead of the internal trigger.
module glitch_frontend #(
  parameter int DIV         = 3,
  parameter int RISING_EDGE = 1,
  parameter int TRIG_CYCLES = 2,
  parameter int N_CYCLES    = 2
) (
  input logic              clk,
  input logic              rst,
  glitch_frontend_if.slave bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW = $clog2(TRIG_CYCLES + 1);
  localparam int BW = $clog2(2 * N_CYCLES);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF   = CW'(DIV / 2);
  localparam logic [TW-1:0] TRIG_LAST  = TW'(TRIG_CYCLES - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(2 * N_CYCLES - 1);

  typedef enum logic {IDLE, BURST} state_t;

  logic [CW-1:0] cnt;
  logic          clean_q;
  logic          s1, s2, s3;
  logic          gpio_edge, fire, fired;
  logic          trig_q;
  logic [TW-1:0] trig_cnt;
  logic          src, src_prev, src_rise;
  state_t        state, state_nxt;
  logic [BW-1:0] bcnt, bcnt_nxt;
  logic          tclk_q, tclk_nxt, busy_q, busy_nxt;

  // Divider: free-running, independent of the glitcher
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      clean_q <= 1'b0;
    end else begin
      cnt     <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      clean_q <= (cnt < CNT_HALF);
    end
  end

  assign gpio_edge = (RISING_EDGE != 0) ? (s2 & ~s3) : (~s2 & s3);
  assign fire      = gpio_edge & bus.arm & ~fired & ~trig_q;

  // Edge detect and trigger: s1/s2 synchronize, s3 holds the previous level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      fired    <= 1'b0;
      trig_q   <= 1'b0;
      trig_cnt <= '0;
    end else begin
      s1 <= bus.target_gpio;
      s2 <= s1;
      s3 <= s2;
      if (!bus.arm)
        fired <= 1'b0;
      else if (fire)
        fired <= 1'b1;
      if (fire) begin
        trig_q   <= 1'b1;
        trig_cnt <= TRIG_LAST;
      end else if (trig_q) begin
        if (trig_cnt == '0)
          trig_q <= 1'b0;
        else
          trig_cnt <= trig_cnt - 1'b1;
      end
    end
  end

`ifdef GLITCH_EXT_TRIG_EN
  assign src = bus.ext_trig;
`else
  assign src = trig_q;
`endif
  assign src_rise = src & ~src_prev;

  // Glitcher state register; target_clk and glitch_busy are registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bcnt     <= '0;
      src_prev <= 1'b0;
      tclk_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      bcnt     <= bcnt_nxt;
      src_prev <= src;
      tclk_q   <= tclk_nxt;
      busy_q   <= busy_nxt;
    end
  end

  // A fire edge arriving on the last burst cycle is dropped, not queued
  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    case (state)
      IDLE: begin
        if (src_rise) begin
          state_nxt = BURST;
          bcnt_nxt  = '0;
        end
      end
      BURST: begin
        if (bcnt == BURST_LAST) begin
          state_nxt = IDLE;
          bcnt_nxt  = '0;
        end else begin
          bcnt_nxt = bcnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        bcnt_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    busy_nxt = (state_nxt == BURST);
    tclk_nxt = (state_nxt == BURST) ? ~bcnt_nxt[0] : clean_q;
  end

  assign bus.trigger     = trig_q;
  assign bus.clean_clk   = clean_q;
  assign bus.target_clk  = tclk_q;
  assign bus.glitch_busy = busy_q;

endmodule

// File: tb/tb_glitch_frontend.sv
// Directed bench for glitch_frontend: per-cycle expectations queued ahead of the clock and
// compared on the falling edge. Covers GLITCH_EXT_TRIG_EN when the macro is defined.
module tb_glitch_frontend;

  localparam int DIV         = 3;
  localparam int TRIG_CYCLES = 2;
  localparam int N_CYCLES    = 2;
`ifdef GLITCH_EXT_TRIG_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  typedef struct {
    logic clean;
    logic tclk;
    logic trig;
    logic busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   k;
  int   ts;
  int   bs;
  exp_t sb[$];

  glitch_frontend_if bus();

  glitch_frontend #(
    .DIV(DIV), .RISING_EDGE(1), .TRIG_CYCLES(TRIG_CYCLES), .N_CYCLES(N_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Expected outputs at the falling edge after the kk-th rising edge since reset release
  function automatic exp_t model(input int kk);
    exp_t e;
    e.clean = (kk >= 1) && (((kk - 1) % DIV) < (DIV / 2));
    e.trig  = (kk >= ts) && (kk < ts + TRIG_CYCLES);
    e.busy  = (kk >= bs) && (kk < bs + 2 * N_CYCLES);
    if (e.busy)
      e.tclk = (((kk - bs) % 2) == 0);
    else
      e.tclk = (kk >= 2) && (((kk - 2) % DIV) < (DIV / 2));
    return e;
  endfunction

  task automatic expect_cycles(input int n, input string tag);
    exp_t e;
    for (int i = 1; i <= n; i++) sb.push_back(model(k + i));
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("%s_clean_k%0d", tag, k), bus.clean_clk,   e.clean);
      check($sformatf("%s_tclk_k%0d",  tag, k), bus.target_clk,  e.tclk);
      check($sformatf("%s_trig_k%0d",  tag, k), bus.trigger,     e.trig);
      check($sformatf("%s_busy_k%0d",  tag, k), bus.glitch_busy, e.busy);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    k   = 0;
    ts  = -1000;
    bs  = -1000;
  endtask

  initial begin
    rst             = 1'b1;
    bus.arm         = 1'b0;
    bus.target_gpio = 1'b0;
`ifdef GLITCH_EXT_TRIG_EN
    bus.ext_trig    = 1'b0;
`endif
    k  = 0;
    ts = -1000;
    bs = -1000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_clean", bus.clean_clk,   1'b0);
    check("rst_tclk",  bus.target_clk,  1'b0);
    check("rst_trig",  bus.trigger,     1'b0);
    check("rst_busy",  bus.glitch_busy, 1'b0);
    rst = 1'b0;

    // Ten clean periods with nothing armed
    expect_cycles(10 * DIV, "div");

    // Armed rising edge fires once; a later edge in the same arm period is ignored
    bus.arm = 1'b1;
    expect_cycles(3, "arm");
    bus.target_gpio = 1'b1;
    ts = k + 3;
    if (!EXT) bs = k + 4;
    expect_cycles(20, "fire1");
    bus.target_gpio = 1'b0;
    expect_cycles(5, "low1");
    bus.target_gpio = 1'b1;
    expect_cycles(10, "oneshot");

    // Edge while disarmed is ignored; re-arming allows one new trigger
    bus.arm = 1'b0;
    bus.target_gpio = 1'b0;
    expect_cycles(6, "disarm");
    bus.target_gpio = 1'b1;
    expect_cycles(10, "unarmed_edge");
    bus.target_gpio = 1'b0;
    expect_cycles(6, "low2");
    bus.arm = 1'b1;
    expect_cycles(3, "rearm");
    bus.target_gpio = 1'b1;
    ts = k + 3;
    if (!EXT) bs = k + 4;
    expect_cycles(15, "fire2");
    bus.target_gpio = 1'b0;
    expect_cycles(5, "low3");
    bus.target_gpio = 1'b1;
    expect_cycles(10, "oneshot2");

    // Reset in the middle of a trigger/burst
    bus.arm = 1'b0;
    bus.target_gpio = 1'b0;
    expect_cycles(3, "disarm2");
    bus.arm = 1'b1;
    expect_cycles(4, "rearm2");
    bus.target_gpio = 1'b1;
    ts = k + 3;
    if (!EXT) bs = k + 4;
    expect_cycles(4, "fire3");
    rst = 1'b1;
    #1;
    check("midrst_clean", bus.clean_clk,   1'b0);
    check("midrst_tclk",  bus.target_clk,  1'b0);
    check("midrst_trig",  bus.trigger,     1'b0);
    check("midrst_busy",  bus.glitch_busy, 1'b0);
    bus.arm = 1'b0;
    bus.target_gpio = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
    expect_cycles(4 * DIV, "restart");

`ifdef GLITCH_EXT_TRIG_EN
    // External fire source: burst from ext_trig, GPIO trigger alone gives no burst
    bus.ext_trig = 1'b1;
    bs = k + 1;
    expect_cycles(1, "ext_fire");
    bus.ext_trig = 1'b0;
    expect_cycles(8, "ext_burst");
    bus.arm = 1'b1;
    expect_cycles(2, "ext_arm");
    bus.target_gpio = 1'b1;
    ts = k + 3;
    expect_cycles(10, "ext_gpio");
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
